weight_control_unit: RTL and testbench



---
 rtl/weight_control_unit.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_weight_control_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : weight_control_unit
//  Purpose  : Producer side of the compute weight handshake. Streams
//             MUL_SIZE x MUL_SIZE weight tiles from weight memory into a
//             two-bank shadow weight buffer and advertises fully written
//             tiles to compute, which consumes them with next_weight_tile_i.
//  Ports    :
//    clk_i, rst_i              clock, synchronous active-high reset
//    instr_valid_i/ready_o     weight-load instruction handshake
//    instr_base_addr_i         word address of row 0 of tile 0
//    instr_num_tiles_i         tiles to stream (0 = no-op)
//    wmem_rd_en_o/addr_o       weight memory read request
//    wmem_rd_data_i            read data, fixed one-cycle latency
//    wbuf_wr_*_o               shadow buffer row write (bank/row/data)
//    compute_weights_rdy_o     at least one full, unconsumed tile buffered
//    rd_bank_o                 bank compute currently reads
//    next_weight_tile_i        compute consumed the current tile (pulse)
//    underrun_o                sticky: consume seen with no ready tile
//    done_o                    pulse when every tile of an instruction is
//                              consumed
//  Config   : define WCU_BACK_TO_BACK_EN to accept a new instruction while
//             draining, so compute sees no gap between instructions.
//  Revision : 1.0 - initial release
// ============================================================================
module weight_control_unit #(
    parameter int MUL_SIZE = 32,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 256,
    parameter int TILES_W  = 6
) (
    input  logic                        clk_i,
    input  logic                        rst_i,

    input  logic                        instr_valid_i,
    input  logic [ADDR_W-1:0]           instr_base_addr_i,
    input  logic [TILES_W-1:0]          instr_num_tiles_i,
    output logic                        instr_ready_o,

    output logic                        wmem_rd_en_o,
    output logic [ADDR_W-1:0]           wmem_addr_o,
    input  logic [DATA_W-1:0]           wmem_rd_data_i,

    output logic                        wbuf_wr_en_o,
    output logic                        wbuf_wr_bank_o,
    output logic [$clog2(MUL_SIZE)-1:0] wbuf_wr_row_o,
    output logic [DATA_W-1:0]           wbuf_wr_data_o,

    output logic                        compute_weights_rdy_o,
    output logic                        rd_bank_o,
    input  logic                        next_weight_tile_i,
    output logic                        underrun_o,
    output logic                        done_o
);

    localparam int ROW_W = $clog2(MUL_SIZE);

    localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(MUL_SIZE - 1);
    localparam logic [1:0]       C_NUM_BANKS = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FETCH     = 2'd1,
        ST_WAIT_SLOT = 2'd2,
        ST_DRAIN     = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    // Latched instruction and fetch position
    logic [ADDR_W-1:0]      r_base;
    logic [TILES_W-1:0]     r_num_tiles;
    logic [TILES_W-1:0]     r_tile;
    logic [ROW_W-1:0]       r_row;
    logic                   r_fetch_bank;

    // Bank bookkeeping
    logic [1:0]             r_occ;       // banks allocated (row 0 issued)
    logic [1:0]             r_rdy_cnt;   // banks fully written
    logic                   r_rdy;
    logic                   r_rd_bank;
    logic                   r_underrun;

    // Single write-pipeline stage aligned with the memory read latency
    logic                   r_wr_en;
    logic [ROW_W-1:0]       r_wr_row;
    logic                   r_wr_bank;

    // Combinational controls
    logic                   w_instr_ready;
    logic                   w_load;
    logic                   w_rd_en;
    logic [ADDR_W-1:0]      w_rd_addr;
    logic                   w_done;
    logic                   w_consume;
    logic                   w_underrun_evt;
    logic                   w_row0;
    logic                   w_row_last;
    logic                   w_slot_free;
    logic [TILES_W-1:0]     w_tile_inc;
    logic [ADDR_W-1:0]      w_fetch_addr;
    logic                   w_occ_inc;
    logic                   w_rdy_inc;
    logic [1:0]             w_occ_nxt;
    logic [1:0]             w_rdy_cnt_nxt;

    // ------------------------------------------------------------------------
    // Consume handling: only a tile that is fully written may be consumed.
    // ------------------------------------------------------------------------
    assign w_consume      = next_weight_tile_i && (r_rdy_cnt != 2'd0);
    assign w_underrun_evt = next_weight_tile_i && (r_rdy_cnt == 2'd0);

    assign w_row0      = (r_row == '0);
    assign w_row_last  = (r_row == C_ROW_LAST);
    assign w_tile_inc  = r_tile + TILES_W'(1);

    // A new tile may claim a bank if one is free now or is freed by a
    // consume in this same cycle.
    assign w_slot_free = (r_occ < C_NUM_BANKS) || w_consume;

    // Address arithmetic deliberately wraps modulo 2^ADDR_W.
    assign w_fetch_addr = r_base
                        + (ADDR_W'(r_tile) * ADDR_W'(MUL_SIZE))
                        + ADDR_W'(r_row);

    // ------------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_instr_ready = 1'b0;
        w_load        = 1'b0;
        w_rd_en       = 1'b0;
        w_rd_addr     = '0;
        w_done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_instr_ready = 1'b1;
                // A zero-tile instruction is accepted and dropped silently.
                if (instr_valid_i && (instr_num_tiles_i != '0)) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (!w_row0 || w_slot_free) begin
                    w_rd_en   = 1'b1;
                    w_rd_addr = w_fetch_addr;
                    if (w_row_last && (w_tile_inc == r_num_tiles)) begin
                        w_state_nxt = ST_DRAIN;
                    end
                end else begin
                    w_state_nxt = ST_WAIT_SLOT;
                end
            end

            ST_WAIT_SLOT: begin
                if (r_occ < C_NUM_BANKS) begin
                    w_state_nxt = ST_FETCH;
                end
            end

            ST_DRAIN: begin
`ifdef WCU_BACK_TO_BACK_EN
                // Chain straight into the next instruction; bank parity and
                // counters carry over so compute sees no bubble.
                w_instr_ready = 1'b1;
                if (instr_valid_i && (instr_num_tiles_i != '0)) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
`endif
                if (!w_load && (r_occ == 2'd0)) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Counter next values; a simultaneous increment and decrement cancel.
    // ------------------------------------------------------------------------
    assign w_occ_inc = w_rd_en && w_row0;
    assign w_rdy_inc = r_wr_en && (r_wr_row == C_ROW_LAST);

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_occ_inc && !w_consume) begin
            w_occ_nxt = r_occ + 2'd1;
        end else if (!w_occ_inc && w_consume) begin
            w_occ_nxt = r_occ - 2'd1;
        end
    end

    always_comb begin
        w_rdy_cnt_nxt = r_rdy_cnt;
        if (w_rdy_inc && !w_consume) begin
            w_rdy_cnt_nxt = r_rdy_cnt + 2'd1;
        end else if (!w_rdy_inc && w_consume) begin
            w_rdy_cnt_nxt = r_rdy_cnt - 2'd1;
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Fetch position and instruction registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_base       <= '0;
            r_num_tiles  <= '0;
            r_tile       <= '0;
            r_row        <= '0;
            r_fetch_bank <= 1'b0;
        end else begin
            if (w_load) begin
                r_base      <= instr_base_addr_i;
                r_num_tiles <= instr_num_tiles_i;
                r_tile      <= '0;
                r_row       <= '0;
            end else if (w_rd_en) begin
                if (w_row_last) begin
                    r_row        <= '0;
                    r_tile       <= w_tile_inc;
                    r_fetch_bank <= ~r_fetch_bank;
                end else begin
                    r_row <= r_row + ROW_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Bank bookkeeping and status flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_occ      <= 2'd0;
            r_rdy_cnt  <= 2'd0;
            r_rdy      <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_occ     <= w_occ_nxt;
            r_rdy_cnt <= w_rdy_cnt_nxt;
            // Registered from the next count so ready rises together with it.
            r_rdy     <= (w_rdy_cnt_nxt != 2'd0);
            if (w_consume) begin
                r_rd_bank <= ~r_rd_bank;
            end
            if (w_underrun_evt) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Write pipeline: the read issued this cycle returns data next cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_en   <= 1'b0;
            r_wr_row  <= '0;
            r_wr_bank <= 1'b0;
        end else begin
            r_wr_en   <= w_rd_en;
            r_wr_row  <= r_row;
            r_wr_bank <= r_fetch_bank;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign instr_ready_o         = w_instr_ready;
    assign wmem_rd_en_o          = w_rd_en;
    assign wmem_addr_o           = w_rd_addr;
    assign wbuf_wr_en_o          = r_wr_en;
    assign wbuf_wr_bank_o        = r_wr_bank;
    assign wbuf_wr_row_o         = r_wr_row;
    // Gated so the data bus stays quiet whenever no row is being written.
    assign wbuf_wr_data_o        = r_wr_en ? wmem_rd_data_i : '0;
    assign compute_weights_rdy_o = r_rdy;
    assign rd_bank_o             = r_rd_bank;
    assign underrun_o            = r_underrun;
    assign done_o                = w_done;

endmodule
`default_nettype wire

// File: tb/tb_weight_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_weight_control_unit
//  Purpose  : Directed self-checking bench for weight_control_unit. Expected
//             memory reads and buffer writes are queued when an instruction
//             is driven and compared as the design produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_weight_control_unit;

    localparam int MUL_SIZE = 32;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 256;
    localparam int TILES_W  = 6;

    logic                clk_i;
    logic                rst_i;
    logic                instr_valid_i;
    logic [ADDR_W-1:0]   instr_base_addr_i;
    logic [TILES_W-1:0]  instr_num_tiles_i;
    logic                instr_ready_o;
    logic                wmem_rd_en_o;
    logic [ADDR_W-1:0]   wmem_addr_o;
    logic [DATA_W-1:0]   wmem_rd_data_i;
    logic                wbuf_wr_en_o;
    logic                wbuf_wr_bank_o;
    logic [4:0]          wbuf_wr_row_o;
    logic [DATA_W-1:0]   wbuf_wr_data_o;
    logic                compute_weights_rdy_o;
    logic                rd_bank_o;
    logic                next_weight_tile_i;
    logic                underrun_o;
    logic                done_o;

    int tests_run = 0;
    int fails     = 0;
    int reads_seen = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic        bank;
        logic [4:0]  row;
    } exp_t;

    exp_t rq[$];
    exp_t wq[$];
    exp_t m_r;
    exp_t m_w;
    logic tb_bank = 1'b0;

    weight_control_unit #(
        .MUL_SIZE (MUL_SIZE),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .TILES_W  (TILES_W)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .instr_valid_i         (instr_valid_i),
        .instr_base_addr_i     (instr_base_addr_i),
        .instr_num_tiles_i     (instr_num_tiles_i),
        .instr_ready_o         (instr_ready_o),
        .wmem_rd_en_o          (wmem_rd_en_o),
        .wmem_addr_o           (wmem_addr_o),
        .wmem_rd_data_i        (wmem_rd_data_i),
        .wbuf_wr_en_o          (wbuf_wr_en_o),
        .wbuf_wr_bank_o        (wbuf_wr_bank_o),
        .wbuf_wr_row_o         (wbuf_wr_row_o),
        .wbuf_wr_data_o        (wbuf_wr_data_o),
        .compute_weights_rdy_o (compute_weights_rdy_o),
        .rd_bank_o             (rd_bank_o),
        .next_weight_tile_i    (next_weight_tile_i),
        .underrun_o            (underrun_o),
        .done_o                (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [DATA_W-1:0] pat(input logic [15:0] a);
        return {16{a ^ 16'h5A3C}};
    endfunction

    // Weight memory model: one-cycle read latency.
    always @(posedge clk_i) begin
        wmem_rd_data_i <= wmem_rd_en_o ? pat(wmem_addr_o) : '0;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (wmem_rd_en_o) begin
                reads_seen++;
                if (rq.size() == 0) begin
                    chk("rd_unexpected", 256'(wmem_rd_en_o), 256'(0));
                end else begin
                    m_r = rq.pop_front();
                    chk("rd_addr", 256'(wmem_addr_o), 256'(m_r.addr));
                end
            end
            if (wbuf_wr_en_o) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected", 256'(wbuf_wr_en_o), 256'(0));
                end else begin
                    m_w = wq.pop_front();
                    chk("wr_bank", 256'(wbuf_wr_bank_o), 256'(m_w.bank));
                    chk("wr_row",  256'(wbuf_wr_row_o),  256'(m_w.row));
                    chk("wr_data", 256'(wbuf_wr_data_o), 256'(pat(m_w.addr)));
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic issue(input logic [15:0] base, input int n);
        exp_t e;
        for (int t = 0; t < n; t++) begin
            for (int r = 0; r < MUL_SIZE; r++) begin
                e.addr = base + 16'(t * MUL_SIZE + r);
                e.bank = tb_bank ^ t[0];
                e.row  = 5'(r);
                rq.push_back(e);
                wq.push_back(e);
            end
        end
        if (n[0]) tb_bank = ~tb_bank;
        instr_valid_i     = 1'b1;
        instr_base_addr_i = base;
        instr_num_tiles_i = TILES_W'(n);
        cyc();
        instr_valid_i     = 1'b0;
    endtask

    task automatic pulse();
        next_weight_tile_i = 1'b1;
        cyc();
        next_weight_tile_i = 1'b0;
    endtask

    task automatic wait_rdy(input string tag);
        for (int c = 0; c < 200 && !compute_weights_rdy_o; c++) cyc();
        chk(tag, 256'(compute_weights_rdy_o), 256'(1));
    endtask

    task automatic wait_sb_empty(input string tag);
        for (int c = 0; c < 300 && (rq.size() != 0 || wq.size() != 0); c++) cyc();
        chk(tag, 256'(rq.size() + wq.size()), 256'(0));
    endtask

    initial begin
        rst_i              = 1'b1;
        instr_valid_i      = 1'b0;
        instr_base_addr_i  = '0;
        instr_num_tiles_i  = '0;
        next_weight_tile_i = 1'b0;

        // ---------------- Reset and idle ----------------
        repeat (3) cyc();
        rst_i = 1'b0;
        repeat (5) cyc();
        chk("rst_ready",    256'(instr_ready_o),         256'(1));
        chk("rst_rdy",      256'(compute_weights_rdy_o), 256'(0));
        chk("rst_rd_en",    256'(wmem_rd_en_o),          256'(0));
        chk("rst_wr_en",    256'(wbuf_wr_en_o),          256'(0));
        chk("rst_done",     256'(done_o),                256'(0));
        chk("rst_underrun", 256'(underrun_o),            256'(0));
        chk("rst_rd_bank",  256'(rd_bank_o),             256'(0));

        // ---------------- Single tile ----------------
        issue(16'h0100, 1);
        for (int i = 0; i < MUL_SIZE; i++) begin
            chk("t1_burst_rd_en", 256'(wmem_rd_en_o), 256'(1));
            cyc();
        end
        chk("t1_rd_end",    256'(wmem_rd_en_o),          256'(0));
        chk("t1_last_wr",   256'(wbuf_wr_en_o),          256'(1));
        chk("t1_last_row",  256'(wbuf_wr_row_o),         256'(31));
        chk("t1_rdy_early", 256'(compute_weights_rdy_o), 256'(0));
        cyc();
        chk("t1_rdy",       256'(compute_weights_rdy_o), 256'(1));
        chk("t1_wr_idle",   256'(wbuf_wr_en_o),          256'(0));
        chk("t1_no_done",   256'(done_o),                256'(0));
        pulse();
        chk("t1_rdy_clr",   256'(compute_weights_rdy_o), 256'(0));
        chk("t1_rd_bank",   256'(rd_bank_o),             256'(1));
        chk("t1_done",      256'(done_o),                256'(1));
        cyc();
        chk("t1_done_pulse", 256'(done_o),               256'(0));
        chk("t1_idle_ready", 256'(instr_ready_o),        256'(1));

        // ---------------- Three tiles, stall on full buffer ----------------
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        tb_bank = 1'b0;
        reads_seen = 0;
        cyc();
        issue(16'h0000, 3);
        for (int c = 0; c < 200 && reads_seen < 64; c++) cyc();
        chk("t3_first64", 256'(reads_seen), 256'(64));
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("t3_stall_rd_en", 256'(wmem_rd_en_o), 256'(0));
        end
        chk("t3_stall_rdy",  256'(compute_weights_rdy_o), 256'(1));
        chk("t3_stall_left", 256'(rq.size()),             256'(32));
        pulse();
        chk("t3_c1_bank", 256'(rd_bank_o),             256'(1));
        chk("t3_c1_rdy",  256'(compute_weights_rdy_o), 256'(1));
        wait_sb_empty("t3_tile2_stream");
        repeat (3) cyc();
        chk("t3_rdy_before_c2", 256'(compute_weights_rdy_o), 256'(1));
        pulse();
        chk("t3_c2_bank", 256'(rd_bank_o),             256'(0));
        chk("t3_c2_rdy",  256'(compute_weights_rdy_o), 256'(1));
        chk("t3_c2_done", 256'(done_o),                256'(0));
        pulse();
        chk("t3_c3_bank", 256'(rd_bank_o),             256'(1));
        chk("t3_c3_rdy",  256'(compute_weights_rdy_o), 256'(0));
        chk("t3_done",    256'(done_o),                256'(1));
        cyc();

        // ---------------- Underrun ----------------
        pulse();
        chk("ur_flag",  256'(underrun_o),            256'(1));
        chk("ur_bank",  256'(rd_bank_o),             256'(1));
        chk("ur_rdy",   256'(compute_weights_rdy_o), 256'(0));
        repeat (3) cyc();
        chk("ur_sticky", 256'(underrun_o),    256'(1));
        chk("ur_ready",  256'(instr_ready_o), 256'(1));

        // ---------------- Address wrap ----------------
        issue(16'hFFF0, 1);
        wait_sb_empty("wrap_stream");
        wait_rdy("wrap_rdy");
        chk("wrap_underrun_kept", 256'(underrun_o), 256'(1));
        pulse();
        chk("wrap_bank", 256'(rd_bank_o), 256'(0));
        chk("wrap_done", 256'(done_o),    256'(1));
        cyc();

        // ---------------- Reset mid-tile ----------------
        issue(16'h0200, 2);
        for (int c = 0; c < 60 && !(wmem_rd_en_o && wmem_addr_o == 16'h020A); c++) cyc();
        chk("mr_row10", 256'(wmem_addr_o), 256'(16'h020A));
        rst_i = 1'b1;
        cyc();
        chk("mr_no_write", 256'(wbuf_wr_en_o),          256'(0));
        chk("mr_rd_en",    256'(wmem_rd_en_o),          256'(0));
        chk("mr_ready",    256'(instr_ready_o),         256'(1));
        chk("mr_rdy",      256'(compute_weights_rdy_o), 256'(0));
        chk("mr_underrun", 256'(underrun_o),            256'(0));
        chk("mr_rd_bank",  256'(rd_bank_o),             256'(0));
        chk("mr_done",     256'(done_o),                256'(0));
        rst_i = 1'b0;
        rq.delete();
        wq.delete();
        tb_bank = 1'b0;
        cyc();
        issue(16'h0300, 1);
        chk("mr_restart_addr", 256'(wmem_addr_o), 256'(16'h0300));
        wait_sb_empty("mr_stream");
        wait_rdy("mr_rdy_after");
        pulse();
        chk("mr_final_bank", 256'(rd_bank_o), 256'(1));
        chk("mr_final_done", 256'(done_o),    256'(1));
        cyc();

        chk("sb_rd_empty", 256'(rq.size()), 256'(0));
        chk("sb_wr_empty", 256'(wq.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
